fpga_input_debounce: RTL and testbench

- Conditions the raw fpga_buttons and fpga_dipsw board inputs before they reach the HPS-visible PIO registers.
- Per bit, it performs the following steps:
  - multi-flop synchronization into the 100 MHz fabric domain;
  - counter-based debounce;
  - rise/fall pulse generation;
  - a sticky, maskable change-event register with an interrupt output.
- One instance is placed per input group, directly upstream of the PIO input ports in the baseline top level.

---
 rtl/fpga_input_debounce.sv | 101 ++++++++++
 tb/tb_fpga_input_debounce.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_input_debounce.sv
// Per-bit input conditioner: synchronizer, counter debounce, edge pulses and
// a sticky maskable change-event register with a registered interrupt.
module fpga_input_debounce #(
    parameter int                WIDTH           = 4,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0]  INIT_VALUE      = '0
) (
    input  logic             system_clock,
    input  logic             system_reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_level,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] evt_pending,
    input  logic [WIDTH-1:0] evt_clear,
    input  logic [WIDTH-1:0] evt_mask,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("fpga_input_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q, irq_d;

    // Plain flop chain; nothing between stages.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= INIT_VALUE;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synced input disagrees with the accepted level.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync_w[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
        pend_d = (pend_q & ~evt_clear) | rise_q | fall_q;
        irq_d  = |(pend_q & evt_mask);
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            db_q   <= INIT_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign db_level    = db_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign evt_pending = pend_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_fpga_input_debounce.sv
// Directed bench for fpga_input_debounce with a run-length reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_fpga_input_debounce;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam logic [W-1:0] INIT = 4'b0000;

    logic         clk = 1'b0;
    logic         system_reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] db_level, rise_pulse, fall_pulse, evt_pending;
    logic [W-1:0] evt_clear, evt_mask;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int rise_cnt [W];
    int fall_cnt [W];

    always #5 clk = ~clk;

    fpga_input_debounce #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .INIT_VALUE(INIT)
    ) dut (
        .system_clock(clk),
        .system_reset(system_reset),
        .raw_in(raw_in),
        .db_level(db_level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .evt_pending(evt_pending),
        .evt_clear(evt_clear),
        .evt_mask(evt_mask),
        .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: input seen SS edges late; a level is accepted once the
    // disagreeing value has been seen on DC consecutive edges.
    logic [W-1:0] dline [$];
    logic [W-1:0] m_db, m_rise, m_fall, m_pend, s;
    logic         m_irq;
    int           run [W];

    always @(posedge clk) begin
        if (system_reset) begin
            dline.delete();
            for (int k = 0; k < SS; k++) dline.push_back(INIT);
            m_db   = INIT;
            m_rise = '0;
            m_fall = '0;
            m_pend = '0;
            m_irq  = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            m_irq  = |(m_pend & evt_mask);
            m_pend = (m_pend & ~evt_clear) | m_rise | m_fall;
            s = dline.pop_front();
            dline.push_back(raw_in);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (s[i] !== m_db[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DC) begin
                        m_db[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
    end

    // Per-cycle comparison and pulse bookkeeping.
    always @(negedge clk) begin
        if (check_en) begin
            check("db_level",    db_level,    m_db);
            check("rise_pulse",  rise_pulse,  m_rise);
            check("fall_pulse",  fall_pulse,  m_fall);
            check("evt_pending", evt_pending, m_pend);
            check("irq",         irq,         m_irq);
            check("rise_and_fall", rise_pulse & fall_pulse, 0);
            for (int i = 0; i < W; i++) begin
                rise_cnt[i] = rise_cnt[i] + int'(rise_pulse[i]);
                fall_cnt[i] = fall_cnt[i] + int'(fall_pulse[i]);
            end
        end
    end

    initial begin
        int r1, r2, tot0, tot1;
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        system_reset = 1'b1;
        raw_in       = 4'b1010;
        evt_clear    = '0;
        evt_mask     = '0;

        // 1: reset values, then release with raw_in != INIT
        tick(1);
        check_en = 1'b1;
        tick(2);
        check("t1_rst_db",   db_level,    4'b0000);
        check("t1_rst_rise", rise_pulse,  4'b0000);
        check("t1_rst_fall", fall_pulse,  4'b0000);
        check("t1_rst_pend", evt_pending, 4'b0000);
        check("t1_rst_irq",  irq,         1'b0);
        tick(2);
        system_reset = 1'b0;
        tick(9);
        check("t1_db_early", db_level,   4'b0000);
        tick(1);
        check("t1_db",       db_level,   4'b1010);
        check("t1_rise",     rise_pulse, 4'b1010);
        tick(1);
        check("t1_rise_end", rise_pulse, 4'b0000);
        check("t1_pend",     evt_pending, 4'b1010);
        evt_clear = 4'b1010;
        tick(1);
        evt_clear = 4'b0000;
        tick(1);
        check("t1_pend_clr", evt_pending, 4'b0000);

        // 2: clean step on bit 0 with interrupt enabled
        evt_mask = 4'b0001;
        raw_in   = 4'b1011;
        tick(9);
        check("t2_db_early", db_level,   4'b1010);
        tick(1);
        check("t2_db",       db_level,   4'b1011);
        check("t2_rise",     rise_pulse, 4'b0001);
        tick(1);
        check("t2_pend",     evt_pending, 4'b0001);
        check("t2_irq_early", irq, 1'b0);
        tick(1);
        check("t2_irq",      irq, 1'b1);
        evt_clear = 4'b0001;
        tick(1);
        evt_clear = 4'b0000;
        tick(2);
        check("t2_irq_clr",  irq, 1'b0);
        evt_mask = 4'b0000;

        // 3: glitch rejection on bit 1
        raw_in[1] = 1'b0;
        tick(12);
        check("t3_db1_low", 32'(db_level[1]), 0);
        r1 = rise_cnt[1];
        raw_in[1] = 1'b1;
        tick(7);
        raw_in[1] = 1'b0;
        tick(12);
        check("t3_glitch_db1",   32'(db_level[1]), 0);
        check("t3_glitch_nrise", rise_cnt[1], r1);
        raw_in[1] = 1'b1;
        tick(8);
        raw_in[1] = 1'b0;
        tick(2);
        check("t3_db1",    32'(db_level[1]),   1);
        check("t3_rise1",  32'(rise_pulse[1]), 1);
        tick(1);
        check("t3_nrise",  rise_cnt[1], r1 + 1);
        tick(12);

        // 4: bouncing edge on bit 2
        r2 = rise_cnt[2];
        for (int k = 0; k < 6; k++) begin
            raw_in[2] = ~raw_in[2];
            tick(3);
        end
        raw_in[2] = 1'b1;
        tick(9);
        check("t4_db2_early", 32'(db_level[2]), 0);
        check("t4_no_rise",   rise_cnt[2], r2);
        tick(1);
        check("t4_rise2",     32'(rise_pulse[2]), 1);
        check("t4_db2",       32'(db_level[2]),   1);
        tick(1);
        check("t4_one_rise",  rise_cnt[2], r2 + 1);

        // 5: set/clear priority on bit 3
        evt_mask  = 4'b1000;
        raw_in[3] = 1'b1;
        tick(12);
        evt_clear = 4'b1000;
        tick(1);
        evt_clear = 4'b0000;
        tick(1);
        check("t5_pend3_clr", 32'(evt_pending[3]), 0);
        check("t5_irq_clr",   irq, 1'b0);
        raw_in[3] = 1'b0;
        tick(10);
        check("t5_fall3", 32'(fall_pulse[3]), 1);
        evt_clear = 4'b1000;
        tick(1);
        check("t5_set_wins", 32'(evt_pending[3]), 1);
        tick(1);
        check("t5_pend3_0",  32'(evt_pending[3]), 0);
        check("t5_irq_1",    irq, 1'b1);
        evt_clear = 4'b0000;
        tick(1);
        check("t5_irq_0",    irq, 1'b0);

        // 6: all bits together, then reset mid-count
        evt_mask = 4'b1111;
        raw_in   = 4'b0000;
        tick(12);
        evt_clear = 4'b1111;
        tick(1);
        evt_clear = 4'b0000;
        tick(1);
        raw_in = 4'b1111;
        tick(9);
        check("t6_db_early", db_level,   4'b0000);
        tick(1);
        check("t6_rise_all", rise_pulse, 4'b1111);
        check("t6_db_all",   db_level,   4'b1111);
        tick(1);
        check("t6_pend_all", evt_pending, 4'b1111);
        raw_in = 4'b0000;
        tick(4);
        tot0 = 0;
        for (int i = 0; i < W; i++) tot0 += rise_cnt[i] + fall_cnt[i];
        system_reset = 1'b1;
        tick(3);
        check("t6_rst_db",   db_level,    INIT);
        check("t6_rst_rise", rise_pulse,  4'b0000);
        check("t6_rst_fall", fall_pulse,  4'b0000);
        check("t6_rst_pend", evt_pending, 4'b0000);
        check("t6_rst_irq",  irq,         1'b0);
        system_reset = 1'b0;
        tick(15);
        tot1 = 0;
        for (int i = 0; i < W; i++) tot1 += rise_cnt[i] + fall_cnt[i];
        check("t6_no_pulses", tot1, tot0);
        check("t6_db_init",   db_level, INIT);

        // Tail: one more mixed pattern after reset
        evt_mask = 4'b0101;
        raw_in   = 4'b0101;
        tick(14);
        check("t7_db", db_level, 4'b0101);
        check("t7_irq", irq, 1'b1);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
